// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 pipelined selector (mux_n_pipe) and its skid slice.
package mux_pkg;

    localparam int MUX_DEFAULT_WIDTH = 16;

    // Occupancy of the 2-entry slice: nothing held, output register only, output + skid.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_pipe_skid_buffer.sv
// skid_buffer: 2-entry valid/ready register slice (output register plus one skid register).
// Valid/ready: a beat moves on a rising edge where valid && ready are both high; the upstream
// side is ready whenever the skid slot is empty (state != SKID_FULL), and the caller derives
// its ready from the exported state.
module skid_buffer
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output skid_state_e      state
);

    typedef logic [WIDTH-1:0] data_t;

    skid_state_e state_q, state_d;
    data_t       out_data_q, out_data_d;
    data_t       skid_data_q, skid_data_d;
    logic        accept;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        accept      = in_valid && (state_q != SKID_FULL);
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    out_data_d = in_data;
                    state_d    = SKID_BUSY;
                end
            end
            SKID_BUSY: begin
                if (out_ready) begin
                    if (accept) out_data_d = in_data;
                    else        state_d    = SKID_EMPTY;
                end else if (accept) begin
                    skid_data_d = in_data;
                    state_d     = SKID_FULL;
                end
            end
            SKID_FULL: begin
                // Upstream is blocked here, so the skid beat always drains before anything newer.
                if (out_ready) begin
                    out_data_d = skid_data_q;
                    state_d    = SKID_BUSY;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = out_data_q;
    assign state     = state_q;

endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N:1 channel selector feeding a flow-controlled 2-entry output slice.
// Optional sticky illegal-select flag enabled by defining MUX_N_SEL_ERR_EN.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = MUX_DEFAULT_WIDTH,
    parameter  int N     = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data [N],
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel_err
);

    typedef logic [WIDTH-1:0] data_t;

    skid_state_e skid_state;
    logic        skid_full;
    logic        sel_hit;
    logic        sel_valid;
    data_t       sel_data;

    assign skid_full = (skid_state == SKID_FULL);

    // sel_hit stays low for sel >= N, which keeps every in_ready low and blocks the accept.
    always_comb begin
        sel_hit   = 1'b0;
        sel_valid = 1'b0;
        sel_data  = '0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_hit     = 1'b1;
                sel_valid   = in_valid[i];
                sel_data    = in_data[i];
                in_ready[i] = !skid_full;
            end
        end
    end

    skid_buffer #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sel_hit && sel_valid),
        .in_data   (sel_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .state     (skid_state)
    );

`ifdef MUX_N_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_err_d = sel_err_q | (!sel_hit && (|in_valid));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err_q <= 1'b0;
        else        sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
